// File: rtl/writeback_arbiter_pkg.sv
// writeback_arbiter_pkg: register-file sizing and the write-back entry type.
package writeback_arbiter_pkg;
  localparam int OPERAND_WIDTH = 16;
  localparam int REGISTER_COUNT = 8;
  localparam int REGISTER_ADDR_WIDTH = $clog2(REGISTER_COUNT);
  localparam int NUM_WB_SOURCES = 2;
  typedef struct packed {
    logic [REGISTER_ADDR_WIDTH-1:0] addr;
    logic [OPERAND_WIDTH-1:0]       data;
  } wb_entry_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant; pointer moves past the winner only on accept.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         accept,
  output logic [N-1:0] grant
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] ptr_q, ptr_d;
  always_comb begin
    int idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx = 0;
    ptr_d = ptr_q;
    for (int o = 0; o < N; o++) begin
      idx = (int'(ptr_q) + o) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found = 1'b1;
        ptr_d = PW'((idx + 1) % N);
      end
    end
    if (!accept) ptr_d = ptr_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) ptr_q <= '0;
    else ptr_q <= ptr_d;
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: stages one round-robin-selected result per cycle and drives it into the
// register cells, holding it while the issue stage reserves the same register.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int NUM_SOURCES = NUM_WB_SOURCES,
  parameter int OPERAND_WIDTH = writeback_arbiter_pkg::OPERAND_WIDTH,
  parameter int REGISTER_COUNT = writeback_arbiter_pkg::REGISTER_COUNT,
  parameter int REGISTER_ADDR_WIDTH = writeback_arbiter_pkg::REGISTER_ADDR_WIDTH
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [NUM_SOURCES-1:0]                           src_valid,
  output logic [NUM_SOURCES-1:0]                           src_ready,
  input  logic [NUM_SOURCES-1:0][REGISTER_ADDR_WIDTH-1:0]  src_addr,
  input  logic [NUM_SOURCES-1:0][OPERAND_WIDTH-1:0]        src_data,
  input  logic [REGISTER_COUNT-1:0]                        write_reserve,
  input  logic [REGISTER_COUNT-1:0]                        reserved,
  output logic [REGISTER_COUNT-1:0]                        write_back,
  output logic [OPERAND_WIDTH-1:0]                         write_data,
  output logic                                             conflict,
  output logic                                             err_unreserved
);
  localparam logic [REGISTER_COUNT-1:0] ONE = REGISTER_COUNT'(1);
  logic                           stg_valid_q, stg_valid_d;
  logic [REGISTER_ADDR_WIDTH-1:0] stg_addr_q, stg_addr_d, sel_addr;
  logic [OPERAND_WIDTH-1:0]       stg_data_q, stg_data_d, sel_data;
  logic                           err_unreserved_q, err_unreserved_d;
  logic [NUM_SOURCES-1:0]         grant;
  logic                           drain, can_load, accept;

  rr_arbiter #(.N(NUM_SOURCES)) u_rr (
    .clk(clk), .rst(rst), .req(src_valid), .accept(accept), .grant(grant)
  );

  // A same-cycle reserve wins in the cell, so the write is withheld and retried.
  always_comb begin
    conflict = stg_valid_q && write_reserve[stg_addr_q];
    drain = stg_valid_q && !conflict;
    can_load = !stg_valid_q || drain;
    accept = can_load && |src_valid;
    src_ready = can_load ? grant : '0;
    write_back = drain ? ONE << stg_addr_q : '0;
    write_data = stg_data_q;
    err_unreserved = err_unreserved_q;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_SOURCES; i++)
      if (grant[i]) begin
        sel_addr = src_addr[i];
        sel_data = src_data[i];
      end
    stg_valid_d = accept ? 1'b1 : drain ? 1'b0 : stg_valid_q;
    stg_addr_d = accept ? sel_addr : stg_addr_q;
    stg_data_d = accept ? sel_data : stg_data_q;
    err_unreserved_d = err_unreserved_q || (drain && !reserved[stg_addr_q]);
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      stg_valid_q <= 1'b0;
      stg_addr_q <= '0;
      stg_data_q <= '0;
      err_unreserved_q <= 1'b0;
    end else begin
      stg_valid_q <= stg_valid_d;
      stg_addr_q <= stg_addr_d;
      stg_data_q <= stg_data_d;
      err_unreserved_q <= err_unreserved_d;
    end
endmodule
